bus0_xmst_arbiter: RTL and testbench



---
 rtl/types_amba_pkg.sv | 52 +++++
 rtl/types_bus0_pkg.sv | 37 +++
 rtl/bus0_xmst_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_bus0_xmst_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_amba_pkg.sv
// AXI4 channel types shared by the system-bus interconnect blocks.
// Master-out / master-in structs carry all five channels; the slave-side
// types are aliases since a slave input is a master output and vice versa.
package types_amba_pkg;

  localparam int unsigned CFG_SYSBUS_ADDR_BITS = 32;
  localparam int unsigned CFG_SYSBUS_DATA_BITS = 64;
  localparam int unsigned CFG_SYSBUS_ID_BITS   = 5;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic [7:0]                      len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
  } axi4_metadata_type;

  typedef struct packed {
    logic                              aw_valid;
    axi4_metadata_type                 aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]     aw_id;
    logic                              w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]   w_data;
    logic                              w_last;
    logic [CFG_SYSBUS_DATA_BITS/8-1:0] w_strb;
    logic                              b_ready;
    logic                              ar_valid;
    axi4_metadata_type                 ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]     ar_id;
    logic                              r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic                            aw_ready;
    logic                            w_ready;
    logic                            b_valid;
    logic [1:0]                      b_resp;
    logic [CFG_SYSBUS_ID_BITS-1:0]   b_id;
    logic                            ar_ready;
    logic                            r_valid;
    logic [1:0]                      r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0] r_data;
    logic                            r_last;
    logic [CFG_SYSBUS_ID_BITS-1:0]   r_id;
  } axi4_master_in_type;

  typedef axi4_master_out_type axi4_slave_in_type;
  typedef axi4_master_in_type  axi4_slave_out_type;

endpackage

// File: rtl/types_bus0_pkg.sv
// System bus 0 configuration: master/slave indices, vector types and the
// address map. Map ranges are [addr_start, addr_end), 64-bit unsigned.
package types_bus0_pkg;
  import types_amba_pkg::*;

  localparam int unsigned CFG_BUS0_XMST_GROUP0 = 0;
  localparam int unsigned CFG_BUS0_XMST_DMA    = 1;
  localparam int unsigned CFG_BUS0_XMST_TOTAL  = 2;

  localparam int unsigned CFG_BUS0_XSLV_BOOTROM = 0;
  localparam int unsigned CFG_BUS0_XSLV_CLINT   = 1;
  localparam int unsigned CFG_BUS0_XSLV_SRAM    = 2;
  localparam int unsigned CFG_BUS0_XSLV_PLIC    = 3;
  localparam int unsigned CFG_BUS0_XSLV_PBRIDGE = 4;
  localparam int unsigned CFG_BUS0_XSLV_DDR     = 5;
  localparam int unsigned CFG_BUS0_XSLV_TOTAL   = 6;

  typedef struct packed {
    logic [63:0] addr_start;
    logic [63:0] addr_end;
  } bus0_mapinfo_type;

  localparam bus0_mapinfo_type CFG_BUS0_MAP [0:CFG_BUS0_XSLV_TOTAL-1] = '{
    '{64'h0000_0000, 64'h0002_0000},   // bootrom
    '{64'h0200_0000, 64'h0201_0000},   // clint
    '{64'h0800_0000, 64'h0820_0000},   // sram
    '{64'h0C00_0000, 64'h1000_0000},   // plic
    '{64'h1000_0000, 64'h1010_0000},   // apb bridge
    '{64'h8000_0000, 64'hC000_0000}    // ddr
  };

  typedef axi4_master_out_type bus0_xmst_out_vector [0:CFG_BUS0_XMST_TOTAL-1];
  typedef axi4_master_in_type  bus0_xmst_in_vector  [0:CFG_BUS0_XMST_TOTAL-1];
  typedef axi4_slave_out_type  bus0_xslv_out_vector [0:CFG_BUS0_XSLV_TOTAL-1];
  typedef axi4_slave_in_type   bus0_xslv_in_vector  [0:CFG_BUS0_XSLV_TOTAL-1];

endpackage

// File: rtl/bus0_xmst_arbiter.sv
// bus0_xmst_arbiter: single-outstanding AXI4 interconnect for system bus 0.
// Arbitrates the bus masters in IDLE, decodes the granted address against
// CFG_BUS0_MAP and routes the whole transaction to one slave; unmapped
// accesses are accepted and answered internally with DECERR.
// Ports:
//   i_clk    - clock, rising edge
//   i_nrst   - asynchronous active-low reset
//   i_xmsto  - master requests;   o_xmsti - master responses/readies
//   i_xslvo  - slave responses;   o_xslvi - slave requests
//   o_busy   - high whenever a transaction is in progress
//   o_decerr - one-cycle pulse after an unmapped grant
// Build option: BUS0_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise fixed priority (lowest master index wins).
module bus0_xmst_arbiter
  import types_amba_pkg::*;
  import types_bus0_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_nrst,
  input  bus0_xmst_out_vector i_xmsto,
  output bus0_xmst_in_vector  o_xmsti,
  input  bus0_xslv_out_vector i_xslvo,
  output bus0_xslv_in_vector  o_xslvi,
  output logic                o_busy,
  output logic                o_decerr
);

  localparam int unsigned MSTW = (CFG_BUS0_XMST_TOTAL > 1) ? $clog2(CFG_BUS0_XMST_TOTAL) : 1;
  localparam int unsigned SLVW = $clog2(CFG_BUS0_XSLV_TOTAL);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] RADDR     = 4'd1;
  localparam logic [3:0] RDATA     = 4'd2;
  localparam logic [3:0] WADDR     = 4'd3;
  localparam logic [3:0] WDATA     = 4'd4;
  localparam logic [3:0] WRESP     = 4'd5;
  localparam logic [3:0] ERR_RDATA = 4'd6;
  localparam logic [3:0] ERR_WDATA = 4'd7;
  localparam logic [3:0] ERR_WRESP = 4'd8;

  logic [3:0]                    state_q, state_d;
  logic [MSTW-1:0]               mst_sel_q, mst_sel_d;
  logic [SLVW-1:0]               slv_sel_q, slv_sel_d;
  logic                          nomatch_q, nomatch_d;
  logic [CFG_SYSBUS_ID_BITS-1:0] id_q, id_d;
  logic [7:0]                    len_q, len_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic                          decerr_q, decerr_d;
`ifdef BUS0_ARB_ROUND_ROBIN_EN
  logic [MSTW-1:0]               rr_q, rr_d;
`endif

  logic [CFG_BUS0_XMST_TOTAL-1:0] req;
  logic                           gnt_any;
  logic [MSTW-1:0]                gnt_idx;
  logic                           gnt_rd;
  logic [63:0]                    gnt_addr;
  logic                           dec_hit;
  logic [SLVW-1:0]                dec_idx;
  axi4_master_out_type            m_o;
  axi4_slave_out_type             s_o;

  always_comb begin
    for (int unsigned i = 0; i < CFG_BUS0_XMST_TOTAL; i++) begin
      req[i] = i_xmsto[i].ar_valid | i_xmsto[i].aw_valid;
    end
  end

  // Arbitration and address decode of the candidate winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef BUS0_ARB_ROUND_ROBIN_EN
    // Search starts one past the last-granted master and wraps.
    for (int unsigned k = 1; k <= CFG_BUS0_XMST_TOTAL; k++) begin
      if (!gnt_any && req[(32'(rr_q) + k) % CFG_BUS0_XMST_TOTAL]) begin
        gnt_any = 1'b1;
        gnt_idx = MSTW'((32'(rr_q) + k) % CFG_BUS0_XMST_TOTAL);
      end
    end
`else
    for (int unsigned i = 0; i < CFG_BUS0_XMST_TOTAL; i++) begin
      if (!gnt_any && req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = MSTW'(i);
      end
    end
`endif
    gnt_rd   = i_xmsto[gnt_idx].ar_valid;
    gnt_addr = gnt_rd ? 64'(i_xmsto[gnt_idx].ar_bits.addr)
                      : 64'(i_xmsto[gnt_idx].aw_bits.addr);
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int unsigned s = 0; s < CFG_BUS0_XSLV_TOTAL; s++) begin
      if (!dec_hit && gnt_addr >= CFG_BUS0_MAP[s].addr_start
                   && gnt_addr <  CFG_BUS0_MAP[s].addr_end) begin
        dec_hit = 1'b1;
        dec_idx = SLVW'(s);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < CFG_BUS0_XMST_TOTAL; i++) o_xmsti[i] = '0;
    for (int unsigned s = 0; s < CFG_BUS0_XSLV_TOTAL; s++) o_xslvi[s] = '0;
    state_d   = state_q;
    mst_sel_d = mst_sel_q;
    slv_sel_d = slv_sel_q;
    nomatch_d = nomatch_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    decerr_d  = 1'b0;
`ifdef BUS0_ARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    m_o = i_xmsto[mst_sel_q];
    s_o = i_xslvo[slv_sel_q];

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          mst_sel_d = gnt_idx;
          slv_sel_d = dec_idx;
          nomatch_d = !dec_hit;
          decerr_d  = !dec_hit;
          id_d      = gnt_rd ? i_xmsto[gnt_idx].ar_id : i_xmsto[gnt_idx].aw_id;
          len_d     = gnt_rd ? i_xmsto[gnt_idx].ar_bits.len : i_xmsto[gnt_idx].aw_bits.len;
          cnt_d     = '0;
          state_d   = gnt_rd ? RADDR : WADDR;
`ifdef BUS0_ARB_ROUND_ROBIN_EN
          rr_d      = gnt_idx;
`endif
        end
      end
      RADDR: begin
        if (nomatch_q) begin
          // Unmapped: accept the address ourselves, then play DECERR beats.
          o_xmsti[mst_sel_q].ar_ready = 1'b1;
          if (m_o.ar_valid) state_d = ERR_RDATA;
        end else begin
          o_xslvi[slv_sel_q].ar_valid = m_o.ar_valid;
          o_xslvi[slv_sel_q].ar_bits  = m_o.ar_bits;
          o_xslvi[slv_sel_q].ar_id    = m_o.ar_id;
          o_xmsti[mst_sel_q].ar_ready = s_o.ar_ready;
          if (m_o.ar_valid && s_o.ar_ready) state_d = RDATA;
        end
      end
      RDATA: begin
        o_xmsti[mst_sel_q].r_valid = s_o.r_valid;
        o_xmsti[mst_sel_q].r_resp  = s_o.r_resp;
        o_xmsti[mst_sel_q].r_data  = s_o.r_data;
        o_xmsti[mst_sel_q].r_last  = s_o.r_last;
        o_xmsti[mst_sel_q].r_id    = s_o.r_id;
        o_xslvi[slv_sel_q].r_ready = m_o.r_ready;
        if (s_o.r_valid && m_o.r_ready && s_o.r_last) state_d = IDLE;
      end
      WADDR: begin
        if (nomatch_q) begin
          o_xmsti[mst_sel_q].aw_ready = 1'b1;
          if (m_o.aw_valid) state_d = ERR_WDATA;
        end else begin
          o_xslvi[slv_sel_q].aw_valid = m_o.aw_valid;
          o_xslvi[slv_sel_q].aw_bits  = m_o.aw_bits;
          o_xslvi[slv_sel_q].aw_id    = m_o.aw_id;
          o_xmsti[mst_sel_q].aw_ready = s_o.aw_ready;
          if (m_o.aw_valid && s_o.aw_ready) state_d = WDATA;
        end
      end
      WDATA: begin
        o_xslvi[slv_sel_q].w_valid = m_o.w_valid;
        o_xslvi[slv_sel_q].w_data  = m_o.w_data;
        o_xslvi[slv_sel_q].w_last  = m_o.w_last;
        o_xslvi[slv_sel_q].w_strb  = m_o.w_strb;
        o_xmsti[mst_sel_q].w_ready = s_o.w_ready;
        if (m_o.w_valid && s_o.w_ready && m_o.w_last) state_d = WRESP;
      end
      WRESP: begin
        o_xmsti[mst_sel_q].b_valid = s_o.b_valid;
        o_xmsti[mst_sel_q].b_resp  = s_o.b_resp;
        o_xmsti[mst_sel_q].b_id    = s_o.b_id;
        o_xslvi[slv_sel_q].b_ready = m_o.b_ready;
        if (s_o.b_valid && m_o.b_ready) state_d = IDLE;
      end
      ERR_RDATA: begin
        o_xmsti[mst_sel_q].r_valid = 1'b1;
        o_xmsti[mst_sel_q].r_resp  = AXI_RESP_DECERR;
        o_xmsti[mst_sel_q].r_id    = id_q;
        o_xmsti[mst_sel_q].r_last  = (cnt_q == len_q);
        if (m_o.r_ready) begin
          if (cnt_q == len_q) state_d = IDLE;
          else                cnt_d   = cnt_q + 8'd1;
        end
      end
      ERR_WDATA: begin
        // Beat count is not checked: the burst ends on w_last.
        o_xmsti[mst_sel_q].w_ready = 1'b1;
        if (m_o.w_valid && m_o.w_last) state_d = ERR_WRESP;
      end
      ERR_WRESP: begin
        o_xmsti[mst_sel_q].b_valid = 1'b1;
        o_xmsti[mst_sel_q].b_resp  = AXI_RESP_DECERR;
        o_xmsti[mst_sel_q].b_id    = id_q;
        if (m_o.b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= IDLE;
      mst_sel_q <= '0;
      slv_sel_q <= '0;
      nomatch_q <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      decerr_q  <= 1'b0;
`ifdef BUS0_ARB_ROUND_ROBIN_EN
      rr_q      <= MSTW'(CFG_BUS0_XMST_TOTAL - 1);
`endif
    end else begin
      state_q   <= state_d;
      mst_sel_q <= mst_sel_d;
      slv_sel_q <= slv_sel_d;
      nomatch_q <= nomatch_d;
      id_q      <= id_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      decerr_q  <= decerr_d;
`ifdef BUS0_ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_decerr = decerr_q;

endmodule

// File: tb/tb_bus0_xmst_arbiter.sv
// Directed self-checking bench for bus0_xmst_arbiter.
module tb_bus0_xmst_arbiter;
  import types_amba_pkg::*;
  import types_bus0_pkg::*;

  logic                clk = 1'b0;
  logic                nrst;
  bus0_xmst_out_vector xmsto;
  bus0_xmst_in_vector  xmsti;
  bus0_xslv_out_vector xslvo;
  bus0_xslv_in_vector  xslvi;
  logic                busy;
  logic                decerr;
  int                  n_chk = 0;
  int                  n_err = 0;

  bus0_xmst_arbiter dut (
    .i_clk    (clk),
    .i_nrst   (nrst),
    .i_xmsto  (xmsto),
    .o_xmsti  (xmsti),
    .i_xslvo  (xslvo),
    .o_xslvi  (xslvi),
    .o_busy   (busy),
    .o_decerr (decerr)
  );

  always #5 clk = ~clk;

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    for (int i = 0; i < int'(CFG_BUS0_XMST_TOTAL); i++) xmsto[i] = '0;
    for (int s = 0; s < int'(CFG_BUS0_XSLV_TOTAL); s++) xslvo[s] = '0;
  endtask

  function automatic logic any_slv_valid();
    logic v = 1'b0;
    for (int s = 0; s < int'(CFG_BUS0_XSLV_TOTAL); s++)
      v = v | xslvi[s].ar_valid | xslvi[s].aw_valid | xslvi[s].w_valid;
    return v;
  endfunction

  function automatic int n_slv_ar();
    int n = 0;
    for (int s = 0; s < int'(CFG_BUS0_XSLV_TOTAL); s++) if (xslvi[s].ar_valid) n++;
    return n;
  endfunction

  // Single-beat read by master m; exp_slv < 0 means the address is unmapped.
  task automatic do_read(input int m, input logic [31:0] addr, input logic [4:0] id,
                         input int exp_slv, input string tag);
    xmsto[m].ar_valid      = 1'b1;
    xmsto[m].ar_bits.addr  = addr;
    xmsto[m].ar_bits.len   = 8'd0;
    xmsto[m].ar_id         = id;
    xmsto[m].r_ready       = 1'b1;
    #1;
    step();
    if (exp_slv < 0) begin
      chk({tag, "_decerr"}, 64'(decerr), 64'd1);
      chk({tag, "_arready"}, 64'(xmsti[m].ar_ready), 64'd1);
      chk({tag, "_noslv"}, 64'(any_slv_valid()), 64'd0);
      step();
      xmsto[m].ar_valid = 1'b0;
      #1;
      chk({tag, "_rresp"}, {xmsti[m].r_valid, xmsti[m].r_last, xmsti[m].r_resp,
                            3'b0, xmsti[m].r_id}, {1'b1, 1'b1, 2'b11, 3'b0, id});
      chk({tag, "_rdata"}, xmsti[m].r_data, 64'd0);
      step();
    end else begin
      chk({tag, "_route"}, 64'(xslvi[exp_slv].ar_valid), 64'd1);
      chk({tag, "_onlyone"}, 64'(n_slv_ar()), 64'd1);
      chk({tag, "_decerr"}, 64'(decerr), 64'd0);
      xslvo[exp_slv].ar_ready = 1'b1;
      #1;
      chk({tag, "_arready"}, 64'(xmsti[m].ar_ready), 64'd1);
      step();
      xmsto[m].ar_valid       = 1'b0;
      xslvo[exp_slv].ar_ready = 1'b0;
      xslvo[exp_slv].r_valid  = 1'b1;
      xslvo[exp_slv].r_last   = 1'b1;
      xslvo[exp_slv].r_data   = 64'(addr) ^ 64'h5A5A;
      xslvo[exp_slv].r_id     = id;
      #1;
      chk({tag, "_rdata"}, xmsti[m].r_data, 64'(addr) ^ 64'h5A5A);
      step();
      xslvo[exp_slv] = '0;
    end
    xmsto[m].r_ready = 1'b0;
    #1;
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  int exp_m;

  initial begin
    clr_in();
    nrst = 1'b0;
    #12;
    // ---- reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_decerr", 64'(decerr), 64'd0);
    chk("rst_m0_in", 64'(xmsti[0].ar_ready | xmsti[0].r_valid | xmsti[0].aw_ready), 64'd0);
    chk("rst_slv", 64'(any_slv_valid()), 64'd0);
    nrst = 1'b1;
    step();

    // ---- mapped read, master 0, sram, len=3
    xmsto[0].ar_valid     = 1'b1;
    xmsto[0].ar_bits.addr = 32'h0800_0000;
    xmsto[0].ar_bits.len  = 8'd3;
    xmsto[0].ar_id        = 5'd5;
    xmsto[0].r_ready      = 1'b1;
    #1;
    chk("rd_idle_noready", 64'(xmsti[0].ar_ready), 64'd0);
    chk("rd_idle_noslv", 64'(any_slv_valid()), 64'd0);
    step();
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_s2_ar", {xslvi[2].ar_valid, 3'b0, xslvi[2].ar_bits.len, xslvi[2].ar_bits.addr},
        {1'b1, 3'b0, 8'd3, 32'h0800_0000});
    chk("rd_s2_arid", 64'(xslvi[2].ar_id), 64'd5);
    chk("rd_onlyone", 64'(n_slv_ar()), 64'd1);
    xslvo[2].ar_ready = 1'b1;
    #1;
    chk("rd_m0_arready", 64'(xmsti[0].ar_ready), 64'd1);
    step();
    xmsto[0].ar_valid = 1'b0;
    xslvo[2].ar_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      xslvo[2].r_valid = 1'b1;
      xslvo[2].r_data  = 64'hA0 + 64'(b);
      xslvo[2].r_last  = (b == 3);
      xslvo[2].r_id    = 5'd5;
      #1;
      chk("rd_beat_data", xmsti[0].r_data, 64'hA0 + 64'(b));
      chk("rd_beat_ctl", {xmsti[0].r_valid, xmsti[0].r_last, xslvi[2].r_ready},
          {1'b1, (b == 3), 1'b1});
      chk("rd_beat_busy", 64'(busy), 64'd1);
      step();
    end
    xslvo[2] = '0;
    xmsto[0].r_ready = 1'b0;
    #1;
    chk("rd_done_idle", 64'(busy), 64'd0);
    chk("rd_done_rvalid", 64'(xmsti[0].r_valid), 64'd0);

    // ---- unmapped write, DMA, len=1
    xmsto[1].aw_valid     = 1'b1;
    xmsto[1].aw_bits.addr = 32'h0400_0000;
    xmsto[1].aw_bits.len  = 8'd1;
    xmsto[1].aw_id        = 5'd7;
    #1;
    step();
    chk("wr_decerr_pulse", 64'(decerr), 64'd1);
    chk("wr_awready", 64'(xmsti[1].aw_ready), 64'd1);
    chk("wr_noslv_aw", 64'(any_slv_valid()), 64'd0);
    step();
    xmsto[1].aw_valid = 1'b0;
    xmsto[1].w_valid  = 1'b1;
    xmsto[1].w_last   = 1'b0;
    xmsto[1].w_data   = 64'h1111;
    #1;
    chk("wr_decerr_once", 64'(decerr), 64'd0);
    chk("wr_wready0", 64'(xmsti[1].w_ready), 64'd1);
    chk("wr_noslv_w", 64'(any_slv_valid()), 64'd0);
    step();
    xmsto[1].w_last = 1'b1;
    #1;
    chk("wr_wready1", 64'(xmsti[1].w_ready), 64'd1);
    step();
    xmsto[1].w_valid = 1'b0;
    xmsto[1].w_last  = 1'b0;
    #1;
    chk("wr_bresp", {xmsti[1].b_valid, xmsti[1].b_resp, xmsti[1].b_id}, {1'b1, 2'b11, 5'd7});
    step();
    chk("wr_bhold", 64'(xmsti[1].b_valid), 64'd1);
    chk("wr_decerr_quiet", 64'(decerr), 64'd0);
    xmsto[1].b_ready = 1'b1;
    step();
    xmsto[1].b_ready = 1'b0;
    #1;
    chk("wr_idle", 64'(busy), 64'd0);

    // ---- map boundaries
    do_read(0, 32'h0001_FFFF, 5'd1, 0, "map_bootrom_top");
    do_read(0, 32'h0002_0000, 5'd2, -1, "map_bootrom_end");
    do_read(1, 32'h0800_0000, 5'd3, 2, "map_sram");
    do_read(1, 32'hBFFF_FFF8, 5'd4, 5, "map_ddr");

    // ---- unmapped read with len=2: three DECERR beats
    xmsto[0].ar_valid     = 1'b1;
    xmsto[0].ar_bits.addr = 32'h2000_0000;
    xmsto[0].ar_bits.len  = 8'd2;
    xmsto[0].ar_id        = 5'd9;
    xmsto[0].r_ready      = 1'b1;
    #1;
    step();
    step();
    xmsto[0].ar_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("err_rd_beat", {xmsti[0].r_valid, xmsti[0].r_last, xmsti[0].r_resp, xmsti[0].r_id},
          {1'b1, (b == 2), 2'b11, 5'd9});
      step();
    end
    xmsto[0].r_ready = 1'b0;
    #1;
    chk("err_rd_idle", 64'(busy), 64'd0);

    // ---- same master: read first, then write after one idle cycle
    xmsto[1].ar_valid     = 1'b1;
    xmsto[1].ar_bits.addr = 32'h0800_0010;
    xmsto[1].ar_id        = 5'd11;
    xmsto[1].aw_valid     = 1'b1;
    xmsto[1].aw_bits.addr = 32'h0800_0020;
    xmsto[1].aw_id        = 5'd12;
    xmsto[1].r_ready      = 1'b1;
    xmsto[1].b_ready      = 1'b1;
    #1;
    step();
    chk("rw_read_first", {xslvi[2].ar_valid, xslvi[2].aw_valid}, 2'b10);
    xslvo[2].ar_ready = 1'b1;
    step();
    xmsto[1].ar_valid = 1'b0;
    xslvo[2].ar_ready = 1'b0;
    xslvo[2].r_valid  = 1'b1;
    xslvo[2].r_last   = 1'b1;
    xslvo[2].r_id     = 5'd11;
    step();
    xslvo[2] = '0;
    #1;
    chk("rw_gap_idle", {busy, xslvi[2].aw_valid}, 2'b00);
    step();
    chk("rw_write_aw", {xslvi[2].aw_valid, xslvi[2].aw_id, xslvi[2].aw_bits.addr},
        {1'b1, 5'd12, 32'h0800_0020});
    xslvo[2].aw_ready = 1'b1;
    #1;
    chk("rw_awready", 64'(xmsti[1].aw_ready), 64'd1);
    step();
    xmsto[1].aw_valid = 1'b0;
    xslvo[2].aw_ready = 1'b0;
    xmsto[1].w_valid  = 1'b1;
    xmsto[1].w_last   = 1'b1;
    xmsto[1].w_data   = 64'hDEAD_BEEF_0BAD_F00D;
    xslvo[2].w_ready  = 1'b1;
    #1;
    chk("rw_wdata", xslvi[2].w_data, 64'hDEAD_BEEF_0BAD_F00D);
    step();
    xmsto[1].w_valid = 1'b0;
    xmsto[1].w_last  = 1'b0;
    xslvo[2].w_ready = 1'b0;
    xslvo[2].b_valid = 1'b1;
    xslvo[2].b_id    = 5'd12;
    #1;
    chk("rw_bfwd", {xmsti[1].b_valid, xmsti[1].b_id, xslvi[2].b_ready}, {1'b1, 5'd12, 1'b1});
    step();
    clr_in();
    #1;
    chk("rw_idle", 64'(busy), 64'd0);

    // ---- reset during RDATA beat 2 of 4
    xmsto[1].ar_valid     = 1'b1;
    xmsto[1].ar_bits.addr = 32'h8000_0000;
    xmsto[1].ar_bits.len  = 8'd3;
    xmsto[1].ar_id        = 5'd3;
    xmsto[1].r_ready      = 1'b1;
    #1;
    step();
    xslvo[5].ar_ready = 1'b1;
    step();
    xmsto[1].ar_valid = 1'b0;
    xslvo[5].ar_ready = 1'b0;
    xslvo[5].r_valid  = 1'b1;
    xslvo[5].r_id     = 5'd3;
    step();
    #1;
    chk("rstm_beat2", 64'(xmsti[1].r_valid), 64'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("rstm_async", {busy, decerr, xmsti[1].r_valid, xslvi[5].r_ready}, 4'b0000);
    clr_in();
    step();
    nrst = 1'b1;

    // ---- simultaneous reads from both masters
    for (int r = 0; r < 3; r++) begin
      xmsto[0].ar_valid     = 1'b1;
      xmsto[0].ar_bits.addr = 32'h0800_0100;
      xmsto[0].ar_id        = 5'd1;
      xmsto[0].r_ready      = 1'b1;
      xmsto[1].ar_valid     = 1'b1;
      xmsto[1].ar_bits.addr = 32'h0800_0200;
      xmsto[1].ar_id        = 5'd2;
      xmsto[1].r_ready      = 1'b1;
`ifdef BUS0_ARB_ROUND_ROBIN_EN
      exp_m = r % 2;
`else
      exp_m = 0;
`endif
      #1;
      step();
      chk("sim_gnt_id", 64'(xslvi[2].ar_id), 64'(exp_m + 1));
      xslvo[2].ar_ready = 1'b1;
      #1;
      chk("sim_arready", {xmsti[0].ar_ready, xmsti[1].ar_ready},
          (exp_m == 0) ? 2'b10 : 2'b01);
      step();
      xslvo[2].ar_ready = 1'b0;
      xslvo[2].r_valid  = 1'b1;
      xslvo[2].r_last   = 1'b1;
      #1;
      chk("sim_rvalid", {xmsti[0].r_valid, xmsti[1].r_valid},
          (exp_m == 0) ? 2'b10 : 2'b01);
      step();
      xslvo[2] = '0;
    end
    xmsto[0] = '0;
    #1;
    step();
    chk("sim_m1_after", {xslvi[2].ar_valid, xslvi[2].ar_id}, {1'b1, 5'd2});
    xslvo[2].ar_ready = 1'b1;
    step();
    xmsto[1].ar_valid = 1'b0;
    xslvo[2].ar_ready = 1'b0;
    xslvo[2].r_valid  = 1'b1;
    xslvo[2].r_last   = 1'b1;
    step();
    clr_in();
    #1;
    chk("sim_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
